// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: blank code and active-low glyph table.
package seg_pkg;

    localparam logic [4:0] CODE_BLANK = 5'h10;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;

    // Active-low gfedcba patterns, element [h] is the glyph for hex digit h.
    localparam logic [15:0][6:0] GLYPH_TAB = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational 5-bit glyph code to active-low segment decoder; the blank bit wins.
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [4:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!code_i[4]) begin
            seg_o = GLYPH_TAB[code_i[3:0]];
        end
    end

endmodule

// File: rtl/seg_scroll_scanner.sv
// Multiplexed N-digit seven-segment scanner with a writable message buffer
// and optional wrap-around left/right scrolling.
module seg_scroll_scanner
    import seg_pkg::*;
#(
    parameter  int unsigned NUM_DIGITS  = 4,
    parameter  int unsigned MSG_DEPTH   = 16,
    parameter  int unsigned REFRESH_DIV = 100000,
    parameter  int unsigned SCROLL_DIV  = 50000000,
    localparam int unsigned AW          = $clog2(MSG_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [4:0]            wr_data,
    input  logic [AW:0]           msg_len,
    input  logic                  scroll_en,
    input  logic                  scroll_dir,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic [AW-1:0]         offset
);

    localparam int unsigned LW = AW + 1;
    localparam int unsigned KW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned RW = $clog2(REFRESH_DIV);
    localparam int unsigned SW = $clog2(SCROLL_DIV);

    logic [4:0]            mem_q [MSG_DEPTH];
    logic [RW-1:0]         rcnt_q, rcnt_d;
    logic [KW-1:0]         k_q, k_d;
    logic [SW-1:0]         scnt_q, scnt_d;
    logic [AW-1:0]         offset_q, offset_d;
    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] an_q;

    logic [LW-1:0] len_eff;
    logic [AW-1:0] len_m1;
    logic          long_msg;
    logic          rterm;
    logic          scroll_run;
    logic          tick;
    logic [LW-1:0] pos_j;
    logic [LW-1:0] off_eff;
    logic [LW:0]   sum;
    logic [LW:0]   wrapped;
    logic [4:0]    rd_code;
    logic [6:0]    seg_c;

    // Effective length and refresh/scroll counters
    always_comb begin
        len_eff    = (msg_len > LW'(MSG_DEPTH)) ? LW'(MSG_DEPTH) : msg_len;
        len_m1     = AW'(len_eff - LW'(1));
        long_msg   = (len_eff >= LW'(NUM_DIGITS));

        rterm      = (rcnt_q == RW'(REFRESH_DIV - 1));
        rcnt_d     = rterm ? '0 : rcnt_q + RW'(1);
        k_d        = k_q;
        if (rterm) begin
            k_d = (k_q == KW'(NUM_DIGITS - 1)) ? '0 : k_q + KW'(1);
        end

        scroll_run = scroll_en && long_msg;
        tick       = scroll_run && (scnt_q == SW'(SCROLL_DIV - 1));
        scnt_d     = (!scroll_run || tick) ? '0 : scnt_q + SW'(1);
    end

    // Offset update: out-of-range clamp has priority over a scroll tick
    always_comb begin
        offset_d = offset_q;
        if (!long_msg || ({1'b0, offset_q} >= len_eff)) begin
            offset_d = '0;
        end else if (tick) begin
            if (!scroll_dir) begin
                offset_d = (offset_q == len_m1) ? '0 : offset_q + AW'(1);
            end else begin
                offset_d = (offset_q == '0) ? len_m1 : offset_q - AW'(1);
            end
        end
    end

    // Buffer read for the selected digit; an offset awaiting its clamp reads as 0
    // so the modulo stays a single conditional subtract.
    always_comb begin
        pos_j   = LW'(NUM_DIGITS - 1) - LW'(k_q);
        off_eff = ({1'b0, offset_q} >= len_eff) ? '0 : {1'b0, offset_q};
        sum     = (LW + 1)'(off_eff) + (LW + 1)'(pos_j);
        wrapped = (sum >= (LW + 1)'(len_eff)) ? sum - (LW + 1)'(len_eff) : sum;
        rd_code = CODE_BLANK;
        if (long_msg) begin
            rd_code = mem_q[AW'(wrapped)];
        end else if (pos_j < len_eff) begin
            rd_code = mem_q[AW'(pos_j)];
        end
    end

    seg_glyph_decode u_decode (
        .code_i (rd_code),
        .seg_o  (seg_c)
    );

    // Message buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(MSG_DEPTH); i++) begin
                mem_q[i] <= CODE_BLANK;
            end
        end else if (wr_en && ({1'b0, wr_addr} < LW'(MSG_DEPTH))) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Counters, offset and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt_q   <= '0;
            k_q      <= '0;
            scnt_q   <= '0;
            offset_q <= '0;
            seg_q    <= SEG_BLANK;
            an_q     <= '1;
        end else begin
            rcnt_q   <= rcnt_d;
            k_q      <= k_d;
            scnt_q   <= scnt_d;
            offset_q <= offset_d;
            seg_q    <= seg_c;
            an_q     <= ~(NUM_DIGITS'(1) << k_q);
        end
    end

    assign seg    = seg_q;
    assign an     = an_q;
    assign offset = offset_q;

endmodule

// File: tb/tb_seg_scroll_scanner.sv
// Self-checking bench for seg_scroll_scanner: vector tables per scenario,
// scoreboard queue of expected digit outputs, hand sequences for scroll timing.
module tb_seg_scroll_scanner;

    localparam int unsigned ND = 4;
    localparam int unsigned MD = 8;
    localparam int unsigned RD = 4;
    localparam int unsigned SD = 16;
    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [4:0]    wr_data = '0;
    logic [AW:0]   msg_len = '0;
    logic          scroll_en = 1'b0;
    logic          scroll_dir = 1'b0;
    logic [6:0]    seg;
    logic [ND-1:0] an;
    logic [AW-1:0] offset;

    seg_scroll_scanner #(
        .NUM_DIGITS  (ND),
        .MSG_DEPTH   (MD),
        .REFRESH_DIV (RD),
        .SCROLL_DIV  (SD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .msg_len    (msg_len),
        .scroll_en  (scroll_en),
        .scroll_dir (scroll_dir),
        .seg        (seg),
        .an         (an),
        .offset     (offset)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         grp;
        string      name;
        logic [3:0] an;
        logic [6:0] seg;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [4:0] d);
        wr_addr = a;
        wr_data = d;
        wr_en   = 1'b1;
        step(1);
        wr_en   = 1'b0;
    endtask

    task automatic wait_an(input logic [3:0] target, output bit found);
        int n = 0;
        while (an !== target && n < 40) begin
            step(1);
            n++;
        end
        found = (an === target);
    endtask

    // Push each vector of a group, wait for its digit to be scanned, pop and compare
    task automatic run_group(input int g);
        vec_t e;
        bit   found;
        foreach (tbl[i]) begin
            if (tbl[i].grp == g) begin
                exp_q.push_back(tbl[i]);
                wait_an(tbl[i].an, found);
                e = exp_q.pop_front();
                if (!found) begin
                    checks++;
                    errors++;
                    $display("FAIL %s: anode %h never selected, last an=%h", e.name, e.an, an);
                end else begin
                    chk({e.name, "_seg"}, 8'(seg), 8'(e.seg));
                end
            end
        end
    endtask

    logic [3:0] frame [4];

    initial begin
        tbl.push_back('{1, "static_d3", 4'h7, 7'h79});
        tbl.push_back('{1, "static_d2", 4'hB, 7'h24});
        tbl.push_back('{1, "static_d1", 4'hD, 7'h30});
        tbl.push_back('{1, "static_d0", 4'hE, 7'h19});
        tbl.push_back('{2, "off5_d3",   4'h7, 7'h12});
        tbl.push_back('{2, "off5_d2",   4'hB, 7'h40});
        tbl.push_back('{2, "off5_d1",   4'hD, 7'h79});
        tbl.push_back('{2, "off5_d0",   4'hE, 7'h24});
        tbl.push_back('{3, "short_d3",  4'h7, 7'h40});
        tbl.push_back('{3, "short_d2",  4'hB, 7'h79});
        tbl.push_back('{3, "short_d1",  4'hD, 7'h7F});
        tbl.push_back('{3, "short_d0",  4'hE, 7'h7F});
        tbl.push_back('{4, "rst_d3",    4'h7, 7'h7F});
        tbl.push_back('{4, "rst_d2",    4'hB, 7'h7F});
        tbl.push_back('{4, "rst_d1",    4'hD, 7'h7F});
        tbl.push_back('{4, "rst_d0",    4'hE, 7'h7F});
        frame = '{4'hE, 4'hD, 4'hB, 4'h7};

        // Reset state
        step(3);
        chk("reset_seg", 8'(seg), 8'h7F);
        chk("reset_an", 8'(an), 8'h0F);
        chk("reset_offset", 8'(offset), 8'h00);

        // First frame with empty message: digit 0 on the first edge, RD-cycle dwell
        rst = 1'b0;
        step(1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("frame%0d_an_start", i), 8'(an), 8'(frame[i % 4]));
            chk($sformatf("frame%0d_seg", i), 8'(seg), 8'h7F);
            step(RD - 1);
            chk($sformatf("frame%0d_an_end", i), 8'(an), 8'(frame[i % 4]));
            step(1);
        end

        // Static glyphs
        wr(3'd0, 5'h01);
        wr(3'd1, 5'h02);
        wr(3'd2, 5'h03);
        wr(3'd3, 5'h04);
        msg_len = 4'd4;
        step(2);
        run_group(1);

        // Left scroll with wrap over a 6-entry message
        for (int i = 0; i < 6; i++) wr(AW'(i), 5'(i));
        msg_len   = 4'd6;
        scroll_en = 1'b1;
        step(SD - 1);
        chk("scroll_before_first_tick", 8'(offset), 8'd0);
        step(1);
        chk("scroll_first_tick", 8'(offset), 8'd1);
        for (int o = 2; o <= 5; o++) begin
            step(SD);
            chk($sformatf("scroll_left_%0d", o), 8'(offset), 8'(o));
        end
        scroll_en = 1'b0;
        step(2);
        chk("scroll_hold_disabled", 8'(offset), 8'd5);
        run_group(2);
        scroll_en = 1'b1;
        step(SD - 1);
        chk("scroll_reenable_wait", 8'(offset), 8'd5);
        step(1);
        chk("scroll_left_wrap", 8'(offset), 8'd0);

        // Right scroll wraps 0 -> len-1
        scroll_dir = 1'b1;
        step(SD - 1);
        chk("scroll_right_wait", 8'(offset), 8'd0);
        step(1);
        chk("scroll_right_wrap", 8'(offset), 8'd5);

        // Short message forces offset 0 and blanks unused digits
        scroll_en = 1'b0;
        msg_len   = 4'd2;
        step(1);
        chk("short_offset_forced", 8'(offset), 8'd0);
        step(2);
        run_group(3);
        scroll_en = 1'b1;
        step(40);
        chk("short_no_scroll", 8'(offset), 8'd0);

        // Clamp wins over a simultaneous tick
        msg_len    = 4'd6;
        scroll_dir = 1'b0;
        step(SD * 5);
        chk("clamp_setup_offset", 8'(offset), 8'd5);
        step(SD - 1);
        chk("clamp_pre_tick", 8'(offset), 8'd5);
        msg_len = 4'd4;
        step(1);
        chk("clamp_vs_tick", 8'(offset), 8'd0);

        // Asynchronous reset mid-dwell clears outputs and buffer
        step(2);
        rst = 1'b1;
        #1;
        chk("midreset_seg", 8'(seg), 8'h7F);
        chk("midreset_an", 8'(an), 8'h0F);
        chk("midreset_offset", 8'(offset), 8'h00);
        step(2);
        rst       = 1'b0;
        scroll_en = 1'b0;
        step(2);
        run_group(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
